// File: rtl/kpn_queue_channel.sv
// kpn_queue_channel
//   KPN channel FIFO whose storage starts out holding initial tokens, so a
//   process network can begin firing without a producer having run first.
//   MODE 0 behaves as an ordinary producer/consumer queue. MODE 1 is a replay
//   source: writes are refused and the precharge tokens are emitted in a loop.
//
//   Parameters
//     DATA_WIDTH       token width
//     ADDR_BITS        depth = 2**ADDR_BITS
//     PRECHARGE_COUNT  tokens valid after reset (0..depth)
//     MODE             0 = FIFO, 1 = replay source
//     INIT_FILE        image name
//     INIT_IMAGE       packed initial contents, entry i at bits
//                      [i*DATA_WIDTH +: DATA_WIDTH]
//
//   Ports
//     clk, reset             rising-edge clock, synchronous active-high reset
//     wr_in, data_in, full   write side; full is combinational
//     rd_in, data_out,       read side; data_out is registered and valid_out
//     valid_out, empty       strobes for one cycle per accepted read
//     count                  occupancy (0..depth)
//     overflow, underflow    sticky error flags, cleared only by reset
module kpn_queue_channel #(
  parameter int                                        DATA_WIDTH      = 16,
  parameter int                                        ADDR_BITS       = 5,
  parameter int                                        PRECHARGE_COUNT = 4,
  parameter int                                        MODE            = 0,
  parameter string                                     INIT_FILE       = "",
  parameter logic [(2**ADDR_BITS)*DATA_WIDTH-1:0]      INIT_IMAGE      = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   PC_CNT  = (ADDR_BITS+1)'(PRECHARGE_COUNT);
  localparam logic [ADDR_BITS-1:0] W_INIT  = ADDR_BITS'(PRECHARGE_COUNT % DEPTH);
  // Index of the last precharge token; only meaningful when PRECHARGE_COUNT > 0.
  localparam logic [ADDR_BITS-1:0] R_LAST  = ADDR_BITS'(PRECHARGE_COUNT - 1);
  localparam bit                   REPLAY  = (MODE != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  r_ptr, w_ptr;
  logic                  rd_acc, wr_acc;

  // Elaboration-time contents only; reset never touches the storage array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = INIT_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Replay mode reports full permanently so producers are always refused.
  assign full   = REPLAY || (count == DEPTH_C);
  assign empty  = (count == '0);
  assign rd_acc = rd_in && !empty;
  assign wr_acc = wr_in && !full;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      w_ptr     <= W_INIT;
      count     <= PC_CNT;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) data_out <= mem[r_ptr];
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (wr_in && full)  overflow  <= 1'b1;
      if (rd_in && empty) underflow <= 1'b1;

      if (REPLAY && rd_acc && (r_ptr == R_LAST)) begin
        // Last precharge token consumed: rewind so the stream repeats.
        r_ptr <= '0;
        count <= PC_CNT;
      end else begin
        if (rd_acc) r_ptr <= r_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kpn_queue_channel.sv
module tb_kpn_queue_channel;
  localparam int DW = 16, AB = 5, DEPTH = 32, PC = 4;
  localparam logic [DEPTH*DW-1:0] IMG =
    {{((DEPTH-4)*DW){1'b0}}, 16'h000D, 16'h000C, 16'h000B, 16'h000A};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO instance (MODE 0)
  logic          rst0 = 1'b1, wr0 = 1'b0, rd0 = 1'b0;
  logic [DW-1:0] din0 = '0, dout0;
  logic          vld0, full0, empty0, ovf0, unf0;
  logic [AB:0]   cnt0;
  // Replay instance (MODE 1)
  logic          rst1 = 1'b1, wr1 = 1'b0, rd1 = 1'b0;
  logic [DW-1:0] din1 = '0, dout1;
  logic          vld1, full1, empty1, ovf1, unf1;
  logic [AB:0]   cnt1;

  int checks = 0, errors = 0;
  logic [DW-1:0] pre [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};

  kpn_queue_channel #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .PRECHARGE_COUNT(PC),
                      .MODE(0), .INIT_IMAGE(IMG)) u_fifo (
    .clk(clk), .reset(rst0), .wr_in(wr0), .data_in(din0), .full(full0),
    .rd_in(rd0), .data_out(dout0), .valid_out(vld0), .empty(empty0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  kpn_queue_channel #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .PRECHARGE_COUNT(PC),
                      .MODE(1), .INIT_IMAGE(IMG)) u_replay (
    .clk(clk), .reset(rst1), .wr_in(wr1), .data_in(din1), .full(full1),
    .rd_in(rd1), .data_out(dout1), .valid_out(vld1), .empty(empty1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b1; rst1 = 1'b1; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    tick; tick;
    rst0 = 1'b0; rst1 = 1'b0;
    checks++; if (cnt0 !== 6'd4) begin errors++; $display("FAIL reset_count: got %0d want 4", cnt0); end
    checks++; if (empty0 !== 1'b0 || full0 !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b want 00", empty0, full0); end
    checks++; if (vld0 !== 1'b0 || dout0 !== 16'h0) begin errors++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0000", vld0, dout0); end
    checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", ovf0, unf0); end
    checks++; if (cnt1 !== 6'd4 || full1 !== 1'b1 || empty1 !== 1'b0) begin errors++; $display("FAIL reset_replay: got c=%0d f=%b e=%b want c=4 f=1 e=0", cnt1, full1, empty1); end
  endtask

  task automatic test_drain;
    rd0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (vld0 !== 1'b1 || dout0 !== pre[i]) begin errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, vld0, dout0, pre[i]); end
    end
    rd0 = 1'b0; tick;
    checks++; if (empty0 !== 1'b1 || cnt0 !== 6'd0) begin errors++; $display("FAIL drain_empty: got e=%b c=%0d want e=1 c=0", empty0, cnt0); end
    checks++; if (vld0 !== 1'b0 || dout0 !== 16'h000D) begin errors++; $display("FAIL drain_hold: got v=%b d=%h want v=0 d=000d", vld0, dout0); end
  endtask

  task automatic test_reset_midstream;
    rst0 = 1'b1; tick; rst0 = 1'b0;
    rd0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (vld0 !== 1'b1 || dout0 !== pre[i]) begin errors++; $display("FAIL mid_pre_%0d: got v=%b d=%h want %h", i, vld0, dout0, pre[i]); end
    end
    rst0 = 1'b1; tick; rst0 = 1'b0;
    checks++; if (vld0 !== 1'b0 || cnt0 !== 6'd4 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%b c=%0d o=%b u=%b want v=0 c=4 o=0 u=0", vld0, cnt0, ovf0, unf0); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (vld0 !== 1'b1 || dout0 !== pre[i]) begin errors++; $display("FAIL mid_restart_%0d: got v=%b d=%h want %h", i, vld0, dout0, pre[i]); end
    end
    rd0 = 1'b0; tick;
  endtask

  task automatic test_fill_wrap;
    wr0 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      din0 = 16'h0100 + 16'(i);
      tick;
      checks++; if (cnt0 !== 6'(i+1) || full0 !== (i == 31)) begin errors++; $display("FAIL fill_%0d: got c=%0d f=%b want c=%0d", i, cnt0, full0, i+1); end
    end
    din0 = 16'hDEAD; tick;
    checks++; if (ovf0 !== 1'b1 || cnt0 !== 6'd32) begin errors++; $display("FAIL fill_overflow: got o=%b c=%0d want o=1 c=32", ovf0, cnt0); end
    wr0 = 1'b0; rd0 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick;
      checks++; if (vld0 !== 1'b1 || dout0 !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL wrap_read_%0d: got v=%b d=%h want %h", i, vld0, dout0, 16'h0100 + 16'(i)); end
    end
    rd0 = 1'b0; tick;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty0); end
  endtask

  task automatic test_simul_wrrd;
    logic [DW-1:0] q[$];
    logic [DW-1:0] e;
    wr0 = 1'b1;
    for (int i = 0; i < 5; i++) begin din0 = 16'h0200 + 16'(i); q.push_back(din0); tick; end
    rd0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din0 = 16'h0300 + 16'(i);
      e = q.pop_front(); q.push_back(din0);
      tick;
      checks++; if (cnt0 !== 6'd5 || vld0 !== 1'b1 || dout0 !== e) begin errors++; $display("FAIL simul_%0d: got c=%0d v=%b d=%h want c=5 d=%h", i, cnt0, vld0, dout0, e); end
    end
    wr0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front(); tick;
      checks++; if (vld0 !== 1'b1 || dout0 !== e) begin errors++; $display("FAIL simul_drain_%0d: got d=%h want %h", i, dout0, e); end
    end
    rd0 = 1'b0; tick;
  endtask

  task automatic test_empty_wrrd;
    checks++; if (unf0 !== 1'b0) begin errors++; $display("FAIL empty_pre_underflow: got %b want 0", unf0); end
    wr0 = 1'b1; rd0 = 1'b1; din0 = 16'h0BEE; tick;
    checks++; if (cnt0 !== 6'd1 || vld0 !== 1'b0 || unf0 !== 1'b1) begin errors++; $display("FAIL empty_wrrd: got c=%0d v=%b u=%b want c=1 v=0 u=1", cnt0, vld0, unf0); end
    wr0 = 1'b0; tick;
    checks++; if (vld0 !== 1'b1 || dout0 !== 16'h0BEE) begin errors++; $display("FAIL empty_followup: got v=%b d=%h want v=1 d=0bee", vld0, dout0); end
    rd0 = 1'b0; tick;
  endtask

  task automatic test_random_fifo;
    logic [DW-1:0] q[$];
    logic [DW-1:0] ed;
    logic ev, movf, munf;
    int pw;
    rst0 = 1'b1; tick; rst0 = 1'b0;
    rd0 = 1'b1; repeat (4) tick; rd0 = 1'b0; tick;  // discard precharge slots
    movf = 0; munf = 0; ed = dout0;
    for (int n = 0; n < 400; n++) begin
      pw = ((n / 48) % 2 == 0) ? 80 : 25;
      wr0 = ($urandom_range(0, 99) < pw);
      rd0 = ($urandom_range(0, 99) < (105 - pw));
      din0 = DW'($urandom);
      // Reference: decisions from the queue length before this cycle.
      ev = rd0 && (q.size() > 0);
      if (wr0 && q.size() == DEPTH) movf = 1;
      if (rd0 && q.size() == 0) munf = 1;
      if (ev) ed = q.pop_front();
      if (wr0 && (q.size() + (ev ? 1 : 0)) < DEPTH + (ev ? 1 : 0) && !(q.size() + (ev ? 1 : 0) == DEPTH)) q.push_back(din0);
      tick;
      checks++; if (vld0 !== ev || (ev && dout0 !== ed)) begin errors++; $display("FAIL rand_data_%0d: got v=%b d=%h want v=%b d=%h", n, vld0, dout0, ev, ed); end
      checks++; if (cnt0 !== 6'(q.size()) || full0 !== (q.size() == DEPTH) || empty0 !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_count_%0d: got c=%0d f=%b e=%b want c=%0d", n, cnt0, full0, empty0, q.size()); end
      checks++; if (ovf0 !== movf || unf0 !== munf) begin errors++; $display("FAIL rand_flags_%0d: got o=%b u=%b want o=%b u=%b", n, ovf0, unf0, movf, munf); end
    end
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  task automatic test_replay;
    int idx;
    logic movf;
    logic exp_v;
    rst1 = 1'b1; tick; rst1 = 1'b0;
    idx = 0; rd1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (vld1 !== 1'b1 || dout1 !== pre[idx]) begin errors++; $display("FAIL replay_seq_%0d: got v=%b d=%h want %h", i, vld1, dout1, pre[idx]); end
      idx = (idx + 1) % PC;
      checks++; if (cnt1 !== 6'(PC - idx)) begin errors++; $display("FAIL replay_count_%0d: got %0d want %0d", i, cnt1, PC - idx); end
    end
    movf = 0;
    for (int n = 0; n < 60; n++) begin
      wr1 = ($urandom_range(0, 1) == 1);
      rd1 = ($urandom_range(0, 3) != 0);
      din1 = DW'($urandom);
      if (wr1) movf = 1;
      exp_v = rd1;
      tick;
      checks++; if (vld1 !== exp_v || (exp_v && dout1 !== pre[idx])) begin errors++; $display("FAIL replay_rand_%0d: got v=%b d=%h want v=%b d=%h", n, vld1, dout1, exp_v, pre[idx]); end
      if (exp_v) idx = (idx + 1) % PC;
      checks++; if (cnt1 !== 6'(PC - idx) || empty1 !== 1'b0 || full1 !== 1'b1 || ovf1 !== movf || unf1 !== 1'b0) begin
        errors++; $display("FAIL replay_state_%0d: got c=%0d e=%b f=%b o=%b u=%b want c=%0d o=%b", n, cnt1, empty1, full1, ovf1, unf1, PC - idx, movf); end
    end
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_drain;
    test_reset_midstream;
    test_fill_wrap;
    test_simul_wrrd;
    test_empty_wrrd;
    test_random_fifo;
    test_replay;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
